// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate-generator pipeline.
//   - RISC-V major opcodes (inst[6:0]) recognised by the decoder.
//   - Format codes reported on the fmt output.
//   - Helpers that extract each immediate format as a 32-bit signed value.
package imm_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational immediate decoder.
// Ports:
//   i_inst    [31:0]      instruction word
//   i_pc      [XLEN-1:0]  address of the instruction
//   o_imm     [XLEN-1:0]  immediate, sign-extended to XLEN
//   o_fmt     [2:0]       format code (fmt_e)
//   o_target  [XLEN-1:0]  i_pc + o_imm, wrapping modulo 2^XLEN
//   o_illegal             opcode not recognised
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      i_inst,
    input  logic [XLEN-1:0]  i_pc,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic [XLEN-1:0]  o_target,
    output logic             o_illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic signed [31:0] w_imm32;
    fmt_e               w_fmt;
    logic               w_illegal;

    always_comb begin
        w_imm32   = '0;
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        case (i_inst[6:0])
            OP_IMM, LOAD, JALR, SYSTEM: begin
                w_fmt   = FMT_I;
                w_imm32 = imm_i(i_inst);
            end
            OP_IMM_32: begin
                if (RV64) begin
                    w_fmt   = FMT_I;
                    w_imm32 = imm_i(i_inst);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            STORE: begin
                w_fmt   = FMT_S;
                w_imm32 = imm_s(i_inst);
            end
            BRANCH: begin
                w_fmt   = FMT_B;
                w_imm32 = imm_b(i_inst);
            end
            JAL: begin
                w_fmt   = FMT_J;
                w_imm32 = imm_j(i_inst);
            end
            LUI, AUIPC: begin
                w_fmt   = FMT_U;
                w_imm32 = imm_u(i_inst);
            end
            OP: begin
                w_fmt = FMT_R;
            end
            OP_32: begin
                if (RV64) begin
                    w_fmt = FMT_R;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Every format fits in 32 signed bits; widening a signed value
    // sign-fills the upper half when XLEN=64.
    assign o_imm     = XLEN'(w_imm32);
    assign o_fmt     = w_fmt;
    assign o_target  = i_pc + o_imm;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: one-stage immediate generator with valid/ready handshake,
// skid buffer and saturating illegal-opcode counter.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid / in_ready      upstream handshake (in_ready is registered)
//   inst [31:0], pc [XLEN]   instruction and its address, sampled on accept
//   out_valid / out_ready    downstream handshake
//   imm, fmt, target,        registered decode results, held stable while
//   illegal                  out_valid && !out_ready
//   illegal_cnt [CNT_W]      saturating count of delivered illegal results
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   imm,
    output logic [2:0]        fmt,
    output logic [XLEN-1:0]   target,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [XLEN-1:0]  w_dec_imm;
    logic [2:0]       w_dec_fmt;
    logic [XLEN-1:0]  w_dec_target;
    logic             w_dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .i_inst    (inst),
        .i_pc      (pc),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_target  (w_dec_target),
        .o_illegal (w_dec_illegal)
    );

    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_imm;
    logic [2:0]        r_out_fmt;
    logic [XLEN-1:0]   r_out_target;
    logic              r_out_illegal;
    logic              r_skid_valid;
    logic [XLEN-1:0]   r_skid_imm;
    logic [2:0]        r_skid_fmt;
    logic [XLEN-1:0]   r_skid_target;
    logic              r_skid_illegal;
    logic [CNT_W-1:0]  r_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_out_free;
    logic w_skid_load;
    logic w_skid_valid_nxt;

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_out_free = !r_out_valid || out_ready;
    // A new result goes to the skid when the output register is held, or
    // when the skid is itself draining into the output register.
    assign w_skid_load      = w_in_fire && (!w_out_free || r_skid_valid);
    assign w_skid_valid_nxt = w_out_free ? (r_skid_valid && w_in_fire)
                                         : (r_skid_valid || w_in_fire);

    // ---- decode -> output register / skid register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_cnt         <= '0;
            r_out_imm     <= '0;
            r_out_fmt     <= FMT_NONE;
            r_out_target  <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            // Registered copy of !skid_valid keeps out_ready off the in_ready path.
            r_in_ready   <= !w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_out_fire && r_out_illegal) begin
                r_cnt <= sat_inc(r_cnt);
            end
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid   <= 1'b1;
                    r_out_imm     <= r_skid_imm;
                    r_out_fmt     <= r_skid_fmt;
                    r_out_target  <= r_skid_target;
                    r_out_illegal <= r_skid_illegal;
                end else if (w_in_fire) begin
                    r_out_valid   <= 1'b1;
                    r_out_imm     <= w_dec_imm;
                    r_out_fmt     <= w_dec_fmt;
                    r_out_target  <= w_dec_target;
                    r_out_illegal <= w_dec_illegal;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid_imm     <= w_dec_imm;
            r_skid_fmt     <= w_dec_fmt;
            r_skid_target  <= w_dec_target;
            r_skid_illegal <= w_dec_illegal;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign imm         = r_out_imm;
    assign fmt         = r_out_fmt;
    assign target      = r_out_target;
    assign illegal     = r_out_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: an RV32 instance (CNT_W=2) and an RV64
// instance (CNT_W=8) share clock and reset.
module tb_imm_gen_pipe;

    logic clk;
    logic rst;

    logic        in_valid32, in_ready32, out_valid32, out_ready32, illegal32;
    logic [31:0] inst32, pc32, imm32, target32;
    logic [2:0]  fmt32;
    logic [1:0]  cnt32;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, illegal64;
    logic [31:0] inst64;
    logic [63:0] pc64, imm64, target64;
    logic [2:0]  fmt64;
    logic [7:0]  cnt64;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .inst(inst32), .pc(pc32), .out_valid(out_valid32), .out_ready(out_ready32),
        .imm(imm32), .fmt(fmt32), .target(target32), .illegal(illegal32),
        .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .inst(inst64), .pc(pc64), .out_valid(out_valid64), .out_ready(out_ready64),
        .imm(imm64), .fmt(fmt64), .target(target64), .illegal(illegal64),
        .illegal_cnt(cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is64;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid32 = 1'b0; inst32 = '0; pc32 = '0; out_ready32 = 1'b1;
        in_valid64 = 1'b0; inst64 = '0; pc64 = '0; out_ready64 = 1'b1;

        vecs[0]  = '{1'b0, 32'hFFF00093, 64'h100,  64'hFFFFFFFF, 3'd1, 64'hFF,       1'b0};
        vecs[1]  = '{1'b0, 32'hFE112E23, 64'h200,  64'hFFFFFFFC, 3'd2, 64'h1FC,      1'b0};
        vecs[2]  = '{1'b0, 32'h00001517, 64'h1000, 64'h00001000, 3'd4, 64'h2000,     1'b0};
        vecs[3]  = '{1'b0, 32'h123452B7, 64'h0,    64'h12345000, 3'd4, 64'h12345000, 1'b0};
        vecs[4]  = '{1'b0, 32'hFE0008E3, 64'h100,  64'hFFFFFFF0, 3'd3, 64'hF0,       1'b0};
        vecs[5]  = '{1'b0, 32'h008000EF, 64'h40,   64'h8,        3'd5, 64'h48,       1'b0};
        vecs[6]  = '{1'b0, 32'hFFDFF0EF, 64'h100,  64'hFFFFFFFC, 3'd5, 64'hFC,       1'b0};
        vecs[7]  = '{1'b0, 32'h002081B3, 64'h300,  64'h0,        3'd0, 64'h300,      1'b0};
        vecs[8]  = '{1'b0, 32'h00412283, 64'h0,    64'h4,        3'd1, 64'h4,        1'b0};
        vecs[9]  = '{1'b0, 32'h000080E7, 64'h20,   64'h0,        3'd1, 64'h20,       1'b0};
        vecs[10] = '{1'b0, 32'h00000073, 64'h0,    64'h0,        3'd1, 64'h0,        1'b0};
        vecs[11] = '{1'b0, 32'h0000007F, 64'h10,   64'h0,        3'd7, 64'h10,       1'b1};
        vecs[12] = '{1'b0, 32'h0010009B, 64'h8,    64'h0,        3'd7, 64'h8,        1'b1};
        vecs[13] = '{1'b0, 32'h002081BB, 64'h8,    64'h0,        3'd7, 64'h8,        1'b1};
        vecs[14] = '{1'b1, 32'h800002B7, 64'h0,    64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80000000, 1'b0};
        vecs[15] = '{1'b1, 32'hFE0008E3, 64'h100,  64'hFFFFFFFFFFFFFFF0, 3'd3, 64'hF0, 1'b0};
        vecs[16] = '{1'b1, 32'h0010009B, 64'h0,    64'h1,        3'd1, 64'h1,        1'b0};
        vecs[17] = '{1'b1, 32'h002081BB, 64'h8,    64'h0,        3'd0, 64'h8,        1'b0};
        vecs[18] = '{1'b1, 32'hFFF00093, 64'h0,    64'hFFFFFFFFFFFFFFFF, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[19] = '{1'b1, 32'h0000007F, 64'h10,   64'h0,        3'd7, 64'h10,       1'b1};
        vecs[20] = '{1'b1, 32'h00001517, 64'hFFFFFFFFFFFFF000, 64'h1000, 3'd4, 64'h0, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst_out_valid32", 64'(out_valid32), 64'd0);
        check("rst_in_ready32",  64'(in_ready32),  64'd0);
        check("rst_cnt32",       64'(cnt32),       64'd0);
        check("rst_fmt32",       64'(fmt32),       64'd7);
        check("rst_imm32",       64'(imm32),       64'd0);
        check("rst_out_valid64", 64'(out_valid64), 64'd0);
        check("rst_fmt64",       64'(fmt64),       64'd7);
        check("rst_target64",    target64,         64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready32", 64'(in_ready32), 64'd1);
        check("post_rst_in_ready64", 64'(in_ready64), 64'd1);

        // Directed decode vectors, out_ready held high
        for (int i = 0; i < NV; i++) begin
            if (!vecs[i].is64) begin
                in_valid32 = 1'b1; inst32 = vecs[i].inst; pc32 = vecs[i].pc[31:0];
            end else begin
                in_valid64 = 1'b1; inst64 = vecs[i].inst; pc64 = vecs[i].pc;
            end
            tick();
            in_valid32 = 1'b0;
            in_valid64 = 1'b0;
            if (!vecs[i].is64) begin
                check($sformatf("v%0d_valid", i),   64'(out_valid32), 64'd1);
                check($sformatf("v%0d_imm", i),     64'(imm32),       vecs[i].imm);
                check($sformatf("v%0d_fmt", i),     64'(fmt32),       64'(vecs[i].fmt));
                check($sformatf("v%0d_target", i),  64'(target32),    vecs[i].tgt);
                check($sformatf("v%0d_illegal", i), 64'(illegal32),   64'(vecs[i].ill));
            end else begin
                check($sformatf("v%0d_valid", i),   64'(out_valid64), 64'd1);
                check($sformatf("v%0d_imm", i),     imm64,            vecs[i].imm);
                check($sformatf("v%0d_fmt", i),     64'(fmt64),       64'(vecs[i].fmt));
                check($sformatf("v%0d_target", i),  target64,         vecs[i].tgt);
                check($sformatf("v%0d_illegal", i), 64'(illegal64),   64'(vecs[i].ill));
            end
        end
        tick();
        check("table_cnt32",   64'(cnt32),       64'd3);
        check("table_cnt64",   64'(cnt64),       64'd1);
        check("table_drain32", 64'(out_valid32), 64'd0);

        // Back-pressure: I0..I5 (addi with imm k+1), out_ready low for 4 cycles
        begin
            int tx = 0;
            int rx = 0;
            int done_cyc = -1;
            for (int cyc = 0; cyc < 30 && rx < 6; cyc++) begin
                out_ready32 = (cyc >= 4);
                in_valid32  = (tx < 6);
                if (tx < 6) begin
                    inst32 = {12'(tx + 1), 5'd0, 3'd0, 5'd1, 7'h13};
                    pc32   = 32'h400 + 32'(tx * 4);
                end
                if (cyc < 4)
                    check("bp_in_ready", 64'(in_ready32), 64'(cyc < 2));
                if (cyc >= 1 && cyc < 4) begin
                    check("bp_hold_valid",  64'(out_valid32), 64'd1);
                    check("bp_hold_imm",    64'(imm32),       64'd1);
                    check("bp_hold_target", 64'(target32),    64'h401);
                end
                if (cyc >= 4)
                    check("bp_stream_valid", 64'(out_valid32), 64'd1);
                if (out_valid32 && out_ready32) begin
                    check("bp_order_imm",    64'(imm32),    64'(rx + 1));
                    check("bp_order_target", 64'(target32), 64'(32'h400 + 32'(rx * 4) + 32'(rx + 1)));
                    rx++;
                    if (rx == 6) done_cyc = cyc;
                end
                if (in_valid32 && in_ready32) tx++;
                tick();
            end
            in_valid32 = 1'b0;
            check("bp_count",    64'(rx),          64'd6);
            check("bp_done_cyc", 64'(done_cyc),    64'd9);
            check("bp_empty",    64'(out_valid32), 64'd0);
        end

        // Reset with both registers full and out_ready low
        out_ready32 = 1'b0;
        in_valid32  = 1'b1; inst32 = 32'h0000007F; pc32 = 32'h0;
        tick();
        inst32 = 32'h0010009B;
        tick();
        check("full_in_ready", 64'(in_ready32), 64'd0);
        rst = 1'b1;
        inst32 = 32'hFFF00093;
        tick();
        rst = 1'b0;
        in_valid32 = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid32), 64'd0);
        check("mid_rst_cnt",       64'(cnt32),       64'd0);
        check("mid_rst_in_ready",  64'(in_ready32),  64'd0);
        check("mid_rst_fmt",       64'(fmt32),       64'd7);
        check("mid_rst_imm",       64'(imm32),       64'd0);
        check("mid_rst_target",    64'(target32),    64'd0);
        check("mid_rst_illegal",   64'(illegal32),   64'd0);
        tick();
        check("after_rst_in_ready",  64'(in_ready32),  64'd1);
        check("after_rst_out_valid", 64'(out_valid32), 64'd0);
        out_ready32 = 1'b1;
        in_valid32  = 1'b1; inst32 = 32'hFFF00093; pc32 = 32'h100;
        tick();
        in_valid32 = 1'b0;
        check("fresh_valid",  64'(out_valid32), 64'd1);
        check("fresh_imm",    64'(imm32),       64'hFFFFFFFF);
        check("fresh_fmt",    64'(fmt32),       64'd1);
        check("fresh_target", 64'(target32),    64'hFF);

        // Saturating counter: five illegal results back to back, CNT_W=2
        for (int k = 0; k <= 5; k++) begin
            in_valid32 = (k < 5);
            inst32 = 32'h0000007F;
            pc32   = 32'h10;
            tick();
            if (k < 5) begin
                check("cnt_valid",   64'(out_valid32), 64'd1);
                check("cnt_illegal", 64'(illegal32),   64'd1);
                check("cnt_fmt",     64'(fmt32),       64'd7);
                check("cnt_imm",     64'(imm32),       64'd0);
            end
            check($sformatf("cnt_value_k%0d", k), 64'(cnt32), 64'((k < 3) ? k : 3));
        end
        in_valid32 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
